// File: rtl/fir_inv_4t.sv
// fir_inv_4t
// Inverse (deconvolution) filter for the 4-tap FIR with coefficients
// h = {1,2,3,4}, i.e. y[n] = x[n] + 2x[n-1] + 3x[n-2] + 4x[n-3] mod 2^19.
// The block recovers x[n] = y[n] - 2x[n-1] - 3x[n-2] - 4x[n-3] (mod 2^19)
// with a serial MAC: one subtraction per state, 1 sample per 4 cycles.
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst       in   synchronous active-high reset
//   in_valid  in   y_in holds a valid filtered sample
//   in_ready  out  high only in IDLE; a sample is accepted on in_valid & in_ready
//   y_in      in   [18:0] filtered sample y[n], unsigned mod 2^19
//   out_valid out  one-cycle pulse, x_out holds a recovered sample
//   x_out     out  [15:0] recovered sample x[n], held between pulses
//   err       out  sticky range-error flag
//
// Optional feature: define FIR_INV_RANGE_CHK_EN to build the range check.
// When defined, err is set (and held until rst) whenever a recovered value
// has any of bits [18:16] set. When undefined, err is tied to 0.

module fir_inv_4t (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] y_in,
  output logic        out_valid,
  output logic [15:0] x_out,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S2   = 2'd2;
  localparam logic [1:0] S3   = 2'd3;

  logic [1:0]  state;
  logic [18:0] acc;
  logic [18:0] h1;
  logic [18:0] h2;
  logic [18:0] h3;

  logic [18:0] two_h1;
  logic [18:0] three_h2;
  logic [18:0] four_h3;
  logic [18:0] r;

  // Coefficient products built from shifts and one add; everything is
  // mod 2^19, so the bits shifted out the top are simply dropped.
  always_comb begin
    two_h1   = {h1[17:0], 1'b0};
    three_h2 = h2 + {h2[17:0], 1'b0};
    four_h3  = {h3[16:0], 2'b00};
    r        = acc - four_h3;
  end

  assign in_ready = (state == IDLE);

  // Main FSM and MAC datapath. The S3 edge finishes the subtraction chain,
  // publishes the result and shifts the history, so a sample accepted in
  // the following (out_valid) cycle already sees the updated history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      h1        <= '0;
      h2        <= '0;
      h3        <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= y_in;
            state <= S1;
          end
        end
        S1: begin
          acc   <= acc - two_h1;
          state <= S2;
        end
        S2: begin
          acc   <= acc - three_h2;
          state <= S3;
        end
        S3: begin
          x_out     <= r[15:0];
          out_valid <= 1'b1;
          h3        <= h2;
          h2        <= h1;
          h1        <= r;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_INV_RANGE_CHK_EN
  // Sticky range flag: a recovered value that does not fit in 16 bits
  // sets err until the next reset. The history still keeps all 19 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == S3 && r[18:16] != 3'b000) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_inv_4t.sv
// tb_fir_inv_4t
// Self-checking bench for fir_inv_4t: a constant vector table for the
// known impulse / two-sample / wrap sequences, hand-written sequences for
// range error, mid-operation reset and back-to-back handshake, and a
// randomized phase compared against a plain-arithmetic reference model.

module tb_fir_inv_4t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] y_in;
  logic        out_valid;
  logic [15:0] x_out;
  logic        err;

  int compared;
  int mismatched;

  fir_inv_4t dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .out_valid (out_valid),
    .x_out     (x_out),
    .err       (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: recovered-sample history and sticky range flag,
  // computed directly from the deconvolution equation.
  longint model_x1, model_x2, model_x3;
  logic   model_err;

  function automatic void modelReset();
    model_x1  = 0;
    model_x2  = 0;
    model_x3  = 0;
    model_err = 1'b0;
  endfunction

  function automatic longint modelStep(input longint y);
    longint t;
    t = (y - 2 * model_x1 - 3 * model_x2 - 4 * model_x3) & 64'h7FFFF;
    model_x3 = model_x2;
    model_x2 = model_x1;
    model_x1 = t;
`ifdef FIR_INV_RANGE_CHK_EN
    if (t > 65535) model_err = 1'b1;
`endif
    return t;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
  endtask

  // Offer one sample, then count edges from the accepting edge until
  // out_valid rises (bounded). Returns the captured x_out and latency.
  task automatic applyStimulus(input logic [18:0] y, output logic [15:0] x, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 10) begin
      tick();
      guard++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    y_in     = y;
    tick();
    in_valid = 1'b0;
    y_in     = 19'($urandom);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    x = x_out;
  endtask

  typedef struct {
    logic        rst_before;
    logic [18:0] y;
    logic [15:0] x;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] x;
    int          lat;
    logic [15:0] held;
    longint      expq[$];
    int          last_accept;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    y_in       = '0;
    modelReset();

    vecs[0] = '{1'b1, 19'd1,      16'd1};
    vecs[1] = '{1'b0, 19'd2,      16'd0};
    vecs[2] = '{1'b0, 19'd3,      16'd0};
    vecs[3] = '{1'b0, 19'd4,      16'd0};
    vecs[4] = '{1'b1, 19'd100,    16'd100};
    vecs[5] = '{1'b0, 19'd400,    16'd200};
    vecs[6] = '{1'b1, 19'd65535,  16'd65535};
    vecs[7] = '{1'b0, 19'd196605, 16'd65535};
    vecs[8] = '{1'b0, 19'd393210, 16'd65535};
    vecs[9] = '{1'b0, 19'd131062, 16'd65535};

    tick();
    doReset();
    checkOutput("reset_in_ready",  in_ready,  1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_x_out",     x_out,     0);
    checkOutput("reset_err",       err,       0);

    // Table-driven known sequences
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_before) doReset();
      applyStimulus(vecs[i].y, x, lat);
      checkOutput($sformatf("vec%0d_x", i), x, vecs[i].x);
      checkOutput($sformatf("vec%0d_latency", i), lat, 4);
      tick();
      checkOutput($sformatf("vec%0d_pulse_width", i), out_valid, 0);
    end
    checkOutput("wrap_err", err, 0);

    // Range error: 70000 needs 17 bits, low 16 bits are 4464
    doReset();
    applyStimulus(19'd70000, x, lat);
    checkOutput("range_x", x, 4464);
    tick();
`ifdef FIR_INV_RANGE_CHK_EN
    checkOutput("range_err_set", err, 1);
    applyStimulus(19'd70000 + 19'd140000, x, lat);
    tick();
    checkOutput("range_err_sticky", err, 1);
`else
    checkOutput("range_err_off", err, 0);
`endif
    doReset();
    checkOutput("range_err_cleared", err, 0);

    // Reset while in S2: no output, no history update
    in_valid = 1'b1;
    y_in     = 19'd500;
    tick();
    in_valid = 1'b0;
    checkOutput("midrst_busy_s1", in_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        if (out_valid) pulses++;
        tick();
      end
      checkOutput("midrst_no_pulse", pulses, 0);
    end
    applyStimulus(19'd7, x, lat);
    checkOutput("midrst_then_7", x, 7);

    // Back-to-back: in_valid held high, random data, model check
    doReset();
    in_valid    = 1'b1;
    last_accept = -1;
    for (int c = 0; c < 40; c++) begin
      y_in = 19'($urandom);
      checkOutput($sformatf("hs_ready_c%0d", c), in_ready, (c % 4 == 0) ? 1 : 0);
      if (out_valid) begin
        if (expq.size() == 0) checkOutput("hs_unexpected_out", 1, 0);
        else checkOutput($sformatf("hs_x_c%0d", c), x_out, expq.pop_front() & 64'hFFFF);
      end
      if (in_ready) begin
        if (last_accept >= 0) checkOutput("hs_accept_gap", c - last_accept, 4);
        last_accept = c;
        expq.push_back(modelStep(y_in));
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid && expq.size() != 0)
        checkOutput("hs_x_tail", x_out, expq.pop_front() & 64'hFFFF);
      tick();
    end
    checkOutput("hs_drained", expq.size(), 0);
    checkOutput("hs_err", err, model_err);

    // Randomized with idle gaps, holding checks between pulses
    doReset();
    for (int i = 0; i < 30; i++) begin
      logic [18:0] y;
      longint      ex;
      y  = (i % 3 == 0) ? 19'($urandom_range(0, 2000)) : 19'($urandom);
      ex = modelStep(y);
      applyStimulus(y, x, lat);
      checkOutput($sformatf("rnd%0d_x", i), x, ex & 64'hFFFF);
      checkOutput($sformatf("rnd%0d_latency", i), lat, 4);
      held = x;
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
      checkOutput($sformatf("rnd%0d_hold", i), x_out, held);
      checkOutput($sformatf("rnd%0d_err", i), err, model_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_inv_4t.md
FIR_INV_4T -- requirements
Module: fir_inv_4t

Inverse (deconvolution) filter for the 4-tap transposed FIR with coefficients h = {1,2,3,4}, where y[n] = x[n] + 2x[n-1] + 3x[n-2] + 4x[n-3] mod 2^19. The block recovers x[n] exactly from y[n] using a serial multiply-accumulate (MAC) datapath.

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: clock; all state updates on posedge clk.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit: y_in holds a valid filtered sample.
REQ-005 Port in_ready, output, 1 bit: block can accept a sample this cycle.
REQ-006 Port y_in, input, 19 bits: filtered sample y[n], unsigned, mod 2^19.
REQ-007 Port out_valid, output, 1 bit: x_out holds a recovered sample; 1-cycle pulse.
REQ-008 Port x_out, output, 16 bits: recovered sample x[n], unsigned.
REQ-009 Port err, output, 1 bit: sticky range-error flag (see Configuration).

Function
REQ-010 The block SHALL compute x[n] = y[n] - 2x[n-1] - 3x[n-2] - 4x[n-3], with all arithmetic mod 2^19 in a 19-bit accumulator acc.
REQ-011 The block SHALL keep three 19-bit history registers h1, h2, h3 holding x[n-1], x[n-2], x[n-3].
REQ-012 The FSM SHALL have four states: IDLE, S1, S2, S3.
REQ-013 in_ready SHALL be 1 if and only if the state is IDLE (combinational decode of state).
REQ-014 In IDLE with in_valid=1: acc <= y_in; next state S1. In IDLE with in_valid=0: remain in IDLE; acc unchanged.
REQ-015 S1: acc <= acc - 2*h1; next state S2.
REQ-016 S2: acc <= acc - 3*h2; next state S3.
REQ-017 S3: r = acc - 4*h3 (19 bits); x_out <= r[15:0]; out_valid <= 1; h3 <= h2; h2 <= h1; h1 <= r; next state IDLE.
REQ-018 out_valid SHALL be registered and high for exactly one cycle, namely the cycle after the S3 edge; otherwise 0.
REQ-019 Latency SHALL be 4 clock edges from the accepting edge to out_valid high. Throughput SHALL be 1 sample per 4 cycles.
REQ-020 A new sample MAY be accepted in the same cycle that out_valid is high; it SHALL use the already-updated history.
REQ-021 The block SHALL apply no output backpressure: x_out is lost if it is not captured on the out_valid cycle.
REQ-022 x_out SHALL hold its last value between out_valid pulses.
REQ-023 in_valid in states S1, S2 and S3 SHALL be ignored; y_in is sampled only on the accepting edge.

Reset
REQ-024 When rst=1 at a posedge: state <= IDLE; acc, h1, h2, h3 <= 0; x_out <= 0; out_valid <= 0; err <= 0.
REQ-025 Reset asserted in S1, S2 or S3 SHALL abort the in-flight sample with no out_valid pulse and no history update.
REQ-026 When rst=1, in_ready SHALL read 1 in the following cycle; rst has priority over in_valid.

Configuration
REQ-027 Macro FIR_INV_RANGE_CHK_EN SHALL control the range check.
- Defined: in S3, if r[18:16] != 0, err <= 1; err stays 1 until reset. x_out and the history still use r (history stores all 19 bits).
- Not defined: err SHALL be constant 0 and no check logic is built.

Verification
REQ-028 Impulse: after reset, drive y = 1, 2, 3, 4 -> x_out = 1, 0, 0, 0; err = 0.
REQ-029 Two samples: drive y = 100, 400 -> x_out = 100, 200; each out_valid occurs 4 cycles after its accept.
REQ-030 Wrap: drive y = 65535, 196605, 393210, 131062 -> x_out = 65535 four times; err = 0.
REQ-031 Range error (macro defined): first y = 70000 -> x_out = 4464, err = 1; err stays 1 across later valid samples until rst.
REQ-032 Reset mid-operation: accept y = 500, assert rst in S2 -> no out_valid, in_ready = 1 next cycle; then y = 7 -> x_out = 7.
REQ-033 Handshake: hold in_valid = 1 continuously -> accepts occur exactly every 4 cycles, and in_ready = 0 in S1 through S3.
